// File: rtl/count_sequencer.sv
// Switch-driven counting sequencer: synchronizes and debounces sw, steps an
// IDLE/RUN/PAUSE machine, divides clk into en_o ticks and counts them on data_o.
module count_sequencer #(
    parameter int CNT_W         = 8,
    parameter int RATIO_W       = 16,
    parameter int DEFAULT_RATIO = 10,
    parameter int DEBOUNCE      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw,
    input  logic [RATIO_W-1:0] ratio_i,
    input  logic               ratio_load_i,
    input  logic               clr_i,
    output logic               en_o,
    output logic [CNT_W-1:0]   data_o,
    output logic               wrap_o,
    output logic [1:0]         state_o
);

    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

    localparam logic [1:0]         S_IDLE    = 2'b00;
    localparam logic [1:0]         S_RUN     = 2'b01;
    localparam logic [1:0]         S_PAUSE   = 2'b10;
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [RATIO_W-1:0] RATIO_RST = RATIO_W'(DEFAULT_RATIO);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    logic               sync1_q, sync2_q;
    logic               db_q, db_d, db_prev_q;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [1:0]         state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] div_q, div_d;
    logic [RATIO_W-1:0] div_last_s;
    logic               en_q, en_d;
    logic [CNT_W-1:0]   data_q, data_d;
    logic               wrap_q, wrap_d;
    logic               press_s;
    logic               tick_s;

    // Debounce: accept the synchronized level after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d     = sync2_q;
                db_cnt_d = {DB_W{1'b0}};
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = {DB_W{1'b0}};
        end
    end

    assign press_s = db_q & ~db_prev_q;

    // Mode machine: clr overrides any press in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = S_IDLE;
        end else if (press_s) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Divider: a zero ratio behaves as a divide-by-one.
    always_comb begin
        if (ratio_q == {RATIO_W{1'b0}}) begin
            div_last_s = {RATIO_W{1'b0}};
        end else begin
            div_last_s = ratio_q - RATIO_W'(1);
        end
        tick_s  = (state_q == S_RUN) && (div_q == div_last_s) && !ratio_load_i && !clr_i;
        ratio_d = ratio_load_i ? ratio_i : ratio_q;
        if (clr_i || ratio_load_i || (state_q == S_IDLE)) begin
            div_d = {RATIO_W{1'b0}};
        end else if (state_q == S_RUN) begin
            div_d = tick_s ? {RATIO_W{1'b0}} : div_q + RATIO_W'(1);
        end else begin
            div_d = div_q;
        end
        en_d = tick_s;
    end

    // Counter advances on the cycle en_o is shown, so the new value appears one cycle later.
    always_comb begin
        if (clr_i) begin
            data_d = {CNT_W{1'b0}};
            wrap_d = 1'b0;
        end else if (en_q) begin
            data_d = data_q + CNT_W'(1);
            wrap_d = (data_q == CNT_MAX);
        end else begin
            data_d = data_q;
            wrap_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= {DB_W{1'b0}};
            state_q   <= S_IDLE;
            ratio_q   <= RATIO_RST;
            div_q     <= {RATIO_W{1'b0}};
            en_q      <= 1'b0;
            data_q    <= {CNT_W{1'b0}};
            wrap_q    <= 1'b0;
        end else begin
            sync1_q   <= sw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            ratio_q   <= ratio_d;
            div_q     <= div_d;
            en_q      <= en_d;
            data_q    <= data_d;
            wrap_q    <= wrap_d;
        end
    end

    assign en_o    = en_q;
    assign data_o  = data_q;
    assign wrap_o  = wrap_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus random
// stimulus compared cycle by cycle against a behavioural reference model.
module tb_count_sequencer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw;
    logic [15:0] ratio_i;
    logic        ratio_load_i;
    logic        clr_i;
    logic        en_o;
    logic [7:0]  data_o;
    logic        wrap_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle / 1 run / 2 pause; phase counts cycles toward the next tick.
    int   m_state, m_phase, m_ratio, m_data;
    bit   m_en, m_wrap, m_db, m_db_prev;
    bit   sw_hist[$];
    bit   syn_hist[$];

    count_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .ratio_i     (ratio_i),
        .ratio_load_i(ratio_load_i),
        .clr_i       (clr_i),
        .en_o        (en_o),
        .data_o      (data_o),
        .wrap_o      (wrap_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int  r;
        bit  press, tk, synced, flip;
        if (rst) begin
            m_state = 0; m_phase = 0; m_ratio = 10; m_data = 0;
            m_en = 1'b0; m_wrap = 1'b0; m_db = 1'b0; m_db_prev = 1'b0;
            sw_hist.delete(); syn_hist.delete();
        end else begin
            r     = (m_ratio == 0) ? 1 : m_ratio;
            press = m_db && !m_db_prev;
            tk    = (m_state == 1) && (m_phase == r - 1) && !ratio_load_i && !clr_i;
            // counter reacts to the tick that is currently visible
            m_wrap = !clr_i && m_en && (m_data == 255);
            m_data = clr_i ? 0 : (m_en ? (m_data + 1) % 256 : m_data);
            if (clr_i || ratio_load_i || m_state == 0) m_phase = 0;
            else if (m_state == 1) m_phase = tk ? 0 : m_phase + 1;
            m_en = tk;
            if (clr_i) m_state = 0;
            else if (press) m_state = (m_state == 1) ? 2 : 1;
            if (ratio_load_i) m_ratio = int'(ratio_i);
            // debounced level flips once the last D synchronized samples all disagree with it
            synced = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size() - 2] : 1'b0;
            syn_hist.push_back(synced);
            flip = (syn_hist.size() >= D);
            for (int i = 0; i < D && flip; i++)
                if (syn_hist[syn_hist.size() - 1 - i] == m_db) flip = 1'b0;
            m_db_prev = m_db;
            if (flip) m_db = !m_db;
            sw_hist.push_back(sw);
            while (sw_hist.size() > 8) void'(sw_hist.pop_front());
            while (syn_hist.size() > 8) void'(syn_hist.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [11:0] model_vec();
        return {m_en, 8'(m_data), m_wrap, 2'(m_state)};
    endfunction

    task automatic press_sw();
        sw = 1'b1;
        repeat (8) tick();
        sw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sw = 1'b0; ratio_i = 16'd0; ratio_load_i = 1'b0; clr_i = 1'b0;
        do_reset();
        checks++;
        if ({en_o, data_o, wrap_o, state_o} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", {en_o, data_o, wrap_o, state_o}, 12'h000);
        end
        tick();
        checks++;
        if ({en_o, data_o, wrap_o, state_o} !== model_vec()) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", {en_o, data_o, wrap_o, state_o}, model_vec());
        end
    endtask

    task automatic test_press_latency();
        int gap;
        sw = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            checks++;
            if (state_o !== ((i == 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL press_latency edge=k+%0d got=%0d exp=%0d", i, state_o, (i == 6) ? 1 : 0);
            end
        end
        gap = 0;
        for (int i = 7; i < 60; i++) begin
            if (i == 10) sw = 1'b0;
            tick();
            checks++;
            if ({en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL run_seq cyc=%0d got=%h exp=%h", i, {en_o, data_o, wrap_o, state_o}, model_vec());
            end
            if (gap == 0 && en_o === 1'b1) gap = i - 6;
        end
        checks++;
        if (gap != 10) begin
            failures++;
            $display("FAIL first_tick got=%0d exp=10", gap);
        end
    endtask

    task automatic test_wrap_pause();
        int   wraps;
        logic [7:0] prev, frozen;
        wraps = 0;
        prev  = data_o;
        for (int i = 0; i < 3000 && wraps == 0; i++) begin
            tick();
            checks++;
            if ({en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL wrap_run cyc=%0d got=%h exp=%h", i, {en_o, data_o, wrap_o, state_o}, model_vec());
            end
            if (wrap_o === 1'b1) begin
                wraps++;
                checks++;
                if (data_o !== 8'd0 || prev !== 8'hff) begin
                    failures++;
                    $display("FAIL wrap_value got=%0h prev=%0h exp=0 prev=ff", data_o, prev);
                end
            end
            prev = data_o;
        end
        checks++;
        if (wraps != 1) begin
            failures++;
            $display("FAIL wrap_seen got=%0d exp=1", wraps);
        end
        press_sw();
        checks++;
        if (state_o !== 2'b10) begin
            failures++;
            $display("FAIL pause_state got=%0d exp=2", state_o);
        end
        frozen = data_o;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (data_o !== frozen || en_o !== 1'b0 || {en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL pause_hold got=%h exp=%h", {en_o, data_o, wrap_o, state_o}, model_vec());
            end
        end
        press_sw();
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if ({en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL resume cyc=%0d got=%h exp=%h", i, {en_o, data_o, wrap_o, state_o}, model_vec());
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        sw = 1'b1;
        repeat (3) tick();
        sw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (state_o !== 2'b00 || {en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL glitch_reject got=%h exp=%h", {en_o, data_o, wrap_o, state_o}, model_vec());
            end
        end
        sw = 1'b1;
        repeat (4) tick();
        sw = 1'b0;
        repeat (12) tick();
        checks++;
        if (state_o !== 2'b01 || m_state != 1) begin
            failures++;
            $display("FAIL glitch_accept got=%0d exp=1", state_o);
        end
    endtask

    task automatic test_ratio_load();
        logic [7:0] d1;
        if (m_state != 1) press_sw();
        ratio_i = 16'd0; ratio_load_i = 1'b1;
        tick();
        ratio_load_i = 1'b0;
        d1 = 8'd0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) d1 = data_o;
            checks++;
            if (en_o !== 1'b1 || (i >= 2 && data_o !== 8'(d1 + 8'(i - 1)))) begin
                failures++;
                $display("FAIL ratio0 i=%0d got en=%0b data=%0h exp en=1 data=%0h", i, en_o, data_o, 8'(d1 + 8'(i - 1)));
            end
        end
        ratio_i = 16'd3; ratio_load_i = 1'b1;
        tick();
        ratio_load_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (en_o !== ((i % 3) == 0) || {en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL ratio3 i=%0d got=%h exp=%h", i, {en_o, data_o, wrap_o, state_o}, model_vec());
            end
        end
    endtask

    task automatic test_clr_coincident();
        int guard;
        ratio_i = 16'd0; ratio_load_i = 1'b1;
        tick();
        ratio_load_i = 1'b0;
        tick();
        sw = 1'b1;
        guard = 0;
        while (!(m_db && !m_db_prev) && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 20 || en_o !== 1'b1) begin
            failures++;
            $display("FAIL clr_setup guard=%0d en=%0b exp en=1", guard, en_o);
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++;
        if ({en_o, data_o, wrap_o, state_o} !== 12'h000) begin
            failures++;
            $display("FAIL clr_press_en got=%h exp=000", {en_o, data_o, wrap_o, state_o});
        end
        sw = 1'b0;
        repeat (10) tick();
        checks++;
        if (state_o !== 2'b00) begin
            failures++;
            $display("FAIL clr_stays_idle got=%0d exp=0", state_o);
        end
    endtask

    task automatic test_rst_mid_run();
        int guard, gap;
        do_reset();
        press_sw();
        ratio_i = 16'd1; ratio_load_i = 1'b1;
        tick();
        ratio_load_i = 1'b0;
        guard = 0;
        while (data_o !== 8'h37 && guard < 200) begin
            if (data_o === 8'h34) sw = 1'b1;
            tick();
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL rst_setup data=%0h exp=37", data_o);
        end
        rst = 1'b1; ratio_i = 16'd5; ratio_load_i = 1'b1; sw = 1'b0;
        tick();
        rst = 1'b0; ratio_load_i = 1'b0;
        checks++;
        if ({en_o, data_o, wrap_o, state_o} !== 12'h000) begin
            failures++;
            $display("FAIL rst_outputs got=%h exp=000", {en_o, data_o, wrap_o, state_o});
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (state_o !== 2'b00 || {en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL rst_idle got=%h exp=%h", {en_o, data_o, wrap_o, state_o}, model_vec());
            end
        end
        sw = 1'b1;
        guard = 0;
        while (state_o !== 2'b01 && guard < 20) begin
            tick();
            guard++;
        end
        gap = 0;
        for (int i = 1; i <= 30 && gap == 0; i++) begin
            if (i == 4) sw = 1'b0;
            tick();
            if (en_o === 1'b1) gap = i;
        end
        checks++;
        if (gap != 10) begin
            failures++;
            $display("FAIL rst_ratio_default got=%0d exp=10", gap);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                sw   = $urandom_range(0, 1);
                hold = $urandom_range(1, 14);
            end
            hold--;
            ratio_load_i = ($urandom_range(0, 49) == 0);
            ratio_i      = 16'($urandom_range(0, 6));
            clr_i        = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if ({en_o, data_o, wrap_o, state_o} !== model_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, {en_o, data_o, wrap_o, state_o}, model_vec());
            end
        end
        ratio_load_i = 1'b0; clr_i = 1'b0; sw = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw = 1'b0; ratio_i = 16'd0; ratio_load_i = 1'b0; clr_i = 1'b0;
        test_reset();
        test_press_latency();
        test_wrap_pause();
        test_glitch();
        test_ratio_load();
        test_clr_coincident();
        test_rst_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
